// File: rtl/lock_pkg.sv
// Shared constants for the combination lock FSM and its access controller.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package lock_pkg;

    // Combination lock FSM state encoding (S0 = idle, S4 = opened)
    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;

    // Lock output value reported by the FSM once the full code is entered
    localparam logic [3:0] OPEN_CODE = 4'hF;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        CHECK   = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/lock_down_counter.sv
// Loadable down-counter shared by the relock and lockout timers.
// Latency: load/decrement visible one cycle after the request; zero is combinational.
// Backpressure: none; decrement holds at zero.
module lock_down_counter #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    // Load has priority over decrement; never wraps below zero
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && (value != '0)) begin
            value <= value - CNT_W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/lock_access_controller.sv
// Key-strobe front end for the combination lock with failure lockout and auto re-lock.
// Latency: strobe one cycle after key rise; pass/fail decision two cycles after the strobe.
// Backpressure: key edges outside ARMED are dropped (OPEN edges force an immediate re-lock).
module lock_access_controller
    import lock_pkg::*;
#(
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int RELOCK_CYCLES  = 500,
    parameter int CNT_W          = 16
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Key1_in,
    input  logic       Key2_in,
    input  logic [3:0] Password_in,
    input  logic       admin_clear,
    input  logic [2:0] fsm_state,
    input  logic [3:0] fsm_Lock,
    output logic       Key1_out,
    output logic       Key2_out,
    output logic [3:0] Password_out,
    output logic       fsm_Reset,
    output logic       locked_out,
    output logic       alarm,
    output logic [3:0] fail_count
);

    localparam logic [3:0] MAX_F = 4'(MAX_FAILS);

    ctrl_state_t      state;
    logic             chk_wait;      // CHECK's first cycle: FSM is still consuming the strobe
    logic             key1_q;
    logic             key2_q;
    logic [2:0]       pre_state;
    logic             rise1;
    logic             rise2;
    logic             any_rise;
    logic             one_rise;
    logic             fail_hit;
    logic             lockout_entry;
    logic [3:0]       fail_next;
    logic             tmr_load;
    logic             tmr_dec;
    logic [CNT_W-1:0] tmr_load_val;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_zero;
    logic             tmr_last;

    assign rise1    = Key1_in & ~key1_q;
    assign rise2    = Key2_in & ~key2_q;
    assign any_rise = rise1 | rise2;
    assign one_rise = rise1 ^ rise2;

    // A failure is a fall back to S0 from a partially entered code; S0->S0 is not counted
    assign fail_hit      = ((pre_state == S1) || (pre_state == S2) || (pre_state == S3)) &&
                           (fsm_state == S0);
    assign fail_next     = (fail_count >= MAX_F) ? MAX_F : fail_count + 4'd1;
    assign lockout_entry = (state == CHECK) && !chk_wait && (fsm_Lock != OPEN_CODE) &&
                           fail_hit && (fail_next == MAX_F);

    // Timer value 1 means this edge is the last one of the timed interval
    assign tmr_last   = tmr_zero || (tmr_value == CNT_W'(1));
    assign locked_out = (state == LOCKOUT);

    // Timer control: load on entry to OPEN/LOCKOUT, count down while in them, clear on early exit
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        case (state)
            CHECK: begin
                if (!chk_wait && (fsm_Lock == OPEN_CODE)) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(RELOCK_CYCLES);
                end else if (lockout_entry && !admin_clear) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(LOCKOUT_CYCLES);
                end
            end
            OPEN: begin
                if (any_rise) tmr_load = 1'b1;
                else          tmr_dec  = 1'b1;
            end
            LOCKOUT: begin
                if (admin_clear) tmr_load = 1'b1;
                else             tmr_dec  = 1'b1;
            end
            default: ;
        endcase
    end

    lock_down_counter #(.CNT_W(CNT_W)) u_timer (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .load       (tmr_load),
        .load_value (tmr_load_val),
        .dec        (tmr_dec),
        .value      (tmr_value),
        .zero       (tmr_zero)
    );

    // Controller FSM with registered strobes, FSM reset pulse, alarm and failure count
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= ARMED;
            chk_wait     <= 1'b0;
            key1_q       <= 1'b0;
            key2_q       <= 1'b0;
            pre_state    <= S0;
            Key1_out     <= 1'b0;
            Key2_out     <= 1'b0;
            Password_out <= 4'd0;
            fsm_Reset    <= 1'b1;
            alarm        <= 1'b0;
            fail_count   <= 4'd0;
        end else begin
            key1_q    <= Key1_in;
            key2_q    <= Key2_in;
            Key1_out  <= 1'b0;
            Key2_out  <= 1'b0;
            fsm_Reset <= 1'b0;
            if (admin_clear) alarm <= 1'b0;
            case (state)
                ARMED: begin
                    if (one_rise) begin
                        Key1_out     <= rise1;
                        Key2_out     <= rise2;
                        Password_out <= Password_in;
                        pre_state    <= fsm_state;
                        chk_wait     <= 1'b1;
                        state        <= CHECK;
                    end
                end
                CHECK: begin
                    if (chk_wait) begin
                        chk_wait <= 1'b0;
                    end else if (fsm_Lock == OPEN_CODE) begin
                        fail_count <= 4'd0;
                        state      <= OPEN;
                    end else if (lockout_entry && !admin_clear) begin
                        fail_count <= fail_next;
                        fsm_Reset  <= 1'b1;
                        alarm      <= 1'b1;
                        state      <= LOCKOUT;
                    end else if (lockout_entry) begin
                        // admin_clear on the same edge cancels the lockout outright
                        fail_count <= 4'd0;
                        state      <= ARMED;
                    end else begin
                        if (fail_hit) fail_count <= fail_next;
                        state <= ARMED;
                    end
                end
                OPEN: begin
                    if (any_rise || tmr_last) begin
                        fsm_Reset <= 1'b1;
                        state     <= ARMED;
                    end
                end
                LOCKOUT: begin
                    if (admin_clear || tmr_last) begin
                        fail_count <= 4'd0;
                        state      <= ARMED;
                    end
                end
                default: state <= ARMED;
            endcase
        end
    end

endmodule
